// File: rtl/onebyeight_demux_bank.sv
// Registered 1-to-8 demux bank: steers each accepted word into one of eight held slots
// by address or auto-increment pointer. Optional done pulse: DEMUX_BANK_DONE_PULSE_EN.
module onebyeight_demux_bank #(
   parameter int SIZE = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [SIZE-1:0] x,
   input  logic [2:0]      OutDemuxAdd,
   input  logic            auto_inc,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            clear,
   output logic [SIZE-1:0] y0,
   output logic [SIZE-1:0] y1,
   output logic [SIZE-1:0] y2,
   output logic [SIZE-1:0] y3,
   output logic [SIZE-1:0] y4,
   output logic [SIZE-1:0] y5,
   output logic [SIZE-1:0] y6,
   output logic [SIZE-1:0] y7,
   output logic [7:0]      y_valid,
   output logic [3:0]      count,
   output logic [2:0]      wr_ptr,
   output logic            full
`ifdef DEMUX_BANK_DONE_PULSE_EN
   ,
   output logic            done
`endif
);

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      FULL    = 2'd2
   } fill_state_t;

   logic [SIZE-1:0] y_q [8];
   logic [SIZE-1:0] y_d [8];
   logic [7:0]      vld_q, vld_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [2:0]      ptr_q, ptr_d;
   fill_state_t     state_q, state_d;
   logic            accept;
   logic [2:0]      slot;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n = n + 4'(v[i]);
      end
      return n;
   endfunction

   // clear outranks a concurrent accept, so the write is masked here
   assign accept = in_valid && in_ready && !clear;
   assign slot   = auto_inc ? ptr_q : OutDemuxAdd;

   always_comb begin
      y_d   = y_q;
      vld_d = vld_q;
      ptr_d = ptr_q;
      if (clear) begin
         vld_d = 8'h00;
         ptr_d = 3'd0;
      end else if (accept) begin
         y_d[slot]   = x;
         vld_d[slot] = 1'b1;
         if (auto_inc) begin
            ptr_d = ptr_q + 3'd1;
         end
      end
      cnt_d = popcount8(vld_d);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: begin
            if (cnt_d == 4'd8)      state_d = FULL;
            else if (cnt_d != 4'd0) state_d = FILLING;
         end
         FILLING: begin
            if (cnt_d == 4'd0)      state_d = EMPTY;
            else if (cnt_d == 4'd8) state_d = FULL;
         end
         FULL: begin
            if (clear)              state_d = EMPTY;
         end
         default:                   state_d = EMPTY;
      endcase
   end

   always_comb begin
      full     = (state_q == FULL);
      in_ready = !(auto_inc && full);
      y_valid  = vld_q;
      count    = cnt_q;
      wr_ptr   = ptr_q;
      y0 = y_q[0];
      y1 = y_q[1];
      y2 = y_q[2];
      y3 = y_q[3];
      y4 = y_q[4];
      y5 = y_q[5];
      y6 = y_q[6];
      y7 = y_q[7];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            y_q[i] <= '0;
         end
         vld_q   <= 8'h00;
         cnt_q   <= 4'd0;
         ptr_q   <= 3'd0;
         state_q <= EMPTY;
      end else begin
         y_q     <= y_d;
         vld_q   <= vld_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         state_q <= state_d;
      end
   end

`ifdef DEMUX_BANK_DONE_PULSE_EN
   logic done_q, done_d;

   // fires only on the entry edge into FULL, never while already there
   assign done_d = (state_d == FULL) && (state_q != FULL);
   assign done   = done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         done_q <= 1'b0;
      end else begin
         done_q <= done_d;
      end
   end
`endif

endmodule

// File: tb/tb_onebyeight_demux_bank.sv
// Scoreboard bench for onebyeight_demux_bank (SIZE=8): a queue-based reference model
// predicts every post-edge state; a monitor compares one prediction per clock.
module tb_onebyeight_demux_bank;

   localparam int SIZE = 8;

   logic            clk;
   logic            rst;
   logic [SIZE-1:0] x;
   logic [2:0]      OutDemuxAdd;
   logic            auto_inc;
   logic            in_valid;
   logic            in_ready;
   logic            clear;
   logic [SIZE-1:0] y0, y1, y2, y3, y4, y5, y6, y7;
   logic [7:0]      y_valid;
   logic [3:0]      count;
   logic [2:0]      wr_ptr;
   logic            full;
`ifdef DEMUX_BANK_DONE_PULSE_EN
   logic            done;
`endif

   onebyeight_demux_bank #(.SIZE(SIZE)) dut (
      .clk(clk), .rst(rst), .x(x), .OutDemuxAdd(OutDemuxAdd), .auto_inc(auto_inc),
      .in_valid(in_valid), .in_ready(in_ready), .clear(clear),
      .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7),
      .y_valid(y_valid), .count(count), .wr_ptr(wr_ptr), .full(full)
`ifdef DEMUX_BANK_DONE_PULSE_EN
      , .done(done)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0][SIZE-1:0] y;
      logic [7:0]           v;
      logic [3:0]           cnt;
      logic [2:0]           ptr;
      logic                 full;
      logic                 rdy;
      logic                 done;
   } exp_t;

   exp_t exp_q[$];
   int   n_total;
   int   n_pass;

   // reference model state
   logic [SIZE-1:0] m_y [8];
   bit              m_v [8];
   int              m_ptr;

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < 8; i++) if (m_v[i]) n++;
      return n;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
   endtask

   task automatic step(input bit r, input logic [SIZE-1:0] d, input logic [2:0] a,
                       input bit ai, input bit iv, input bit cl);
      exp_t e;
      bit   full_before, full_after, ready;
      int   s;
      @(negedge clk);
      rst = r; x = d; OutDemuxAdd = a; auto_inc = ai; in_valid = iv; clear = cl;
      full_before = (m_count() == 8);
      ready = !(ai && full_before);
      if (r) begin
         for (int i = 0; i < 8; i++) begin m_y[i] = '0; m_v[i] = 0; end
         m_ptr = 0;
      end else if (cl) begin
         for (int i = 0; i < 8; i++) m_v[i] = 0;
         m_ptr = 0;
      end else if (iv && ready) begin
         s = ai ? m_ptr : int'(a);
         m_y[s] = d;
         m_v[s] = 1;
         if (ai) m_ptr = (m_ptr + 1) % 8;
      end
      full_after = (m_count() == 8);
      for (int i = 0; i < 8; i++) begin
         e.y[i] = m_y[i];
         e.v[i] = m_v[i];
      end
      e.cnt  = 4'(m_count());
      e.ptr  = 3'(m_ptr);
      e.full = full_after;
      e.rdy  = !(ai && full_after);
      e.done = !r && full_after && !full_before;
      exp_q.push_back(e);
   endtask

   logic [7:0][SIZE-1:0] dut_y;
   assign dut_y = {y7, y6, y5, y4, y3, y2, y1, y0};

   // monitor: one prediction per edge, sampled 1 time unit after it
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < 8; i++) chk($sformatf("y%0d", i), 64'(dut_y[i]), 64'(e.y[i]));
            chk("y_valid", 64'(y_valid), 64'(e.v));
            chk("count", 64'(count), 64'(e.cnt));
            chk("wr_ptr", 64'(wr_ptr), 64'(e.ptr));
            chk("full", 64'(full), 64'(e.full));
            chk("in_ready", 64'(in_ready), 64'(e.rdy));
`ifdef DEMUX_BANK_DONE_PULSE_EN
            chk("done", 64'(done), 64'(e.done));
`endif
         end
      end
   end

   initial begin
      int wait_cyc;
      n_total = 0; n_pass = 0;
      rst = 1'b1; x = '0; OutDemuxAdd = 3'd0; auto_inc = 1'b0; in_valid = 1'b1; clear = 1'b0;
      for (int i = 0; i < 8; i++) begin m_y[i] = '0; m_v[i] = 0; end
      m_ptr = 0;

      // reset held two cycles with a write request present
      step(1, 8'h5A, 3'd3, 0, 1, 0);
      step(1, 8'hA5, 3'd4, 1, 1, 0);

      // auto fill 0x10..0x17, then a ninth write that must be ignored
      for (int i = 0; i < 8; i++) step(0, 8'(8'h10 + i), 3'd0, 1, 1, 0);
      step(0, 8'h99, 3'd0, 1, 1, 0);
      step(0, 8'h00, 3'd0, 1, 0, 0);

      // clear collides with a direct write while full
      step(0, 8'hFF, 3'd2, 0, 1, 1);
      step(0, 8'h00, 3'd0, 0, 0, 0);

      // direct overwrite of slot 5
      step(0, 8'hAA, 3'd5, 0, 1, 0);
      step(0, 8'hAA, 3'd5, 0, 1, 0);
      step(0, 8'h55, 3'd5, 0, 1, 0);
      step(0, 8'h00, 3'd0, 0, 0, 1);

      // mixed mode: auto, auto, direct 7, auto
      step(0, 8'h21, 3'd0, 1, 1, 0);
      step(0, 8'h22, 3'd4, 1, 1, 0);
      step(0, 8'h23, 3'd7, 0, 1, 0);
      step(0, 8'h24, 3'd1, 1, 1, 0);
      step(0, 8'h00, 3'd0, 0, 0, 1);

      // fill to full, idle, then overwrite while full (no second completion)
      for (int i = 0; i < 8; i++) step(0, 8'(8'h30 + i), 3'd0, 1, 1, 0);
      step(0, 8'h00, 3'd0, 1, 0, 0);
      step(0, 8'hC3, 3'd3, 0, 1, 0);
      step(0, 8'h00, 3'd0, 0, 0, 0);
      step(0, 8'h00, 3'd0, 0, 0, 1);

      // randomized traffic with occasional clear and reset
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 63) == 0), 8'($urandom), 3'($urandom),
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
              $urandom_range(0, 15) == 0);
      end
      step(0, 8'h00, 3'd0, 0, 0, 0);

      wait_cyc = 0;
      while (exp_q.size() > 0 && wait_cyc < 10) begin
         @(posedge clk);
         wait_cyc++;
      end
      #2;
      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
